// File: rtl/alu_issue_stage.sv
// EX-stage issue register: decodes ALUOp/funct3/funct7[5] into an ALU operation and holds
// the operand bundle in a 2-entry skid buffer. Define ALU_ISSUE_PERF_EN to add perf counters.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [2:0]               funct3,
  input  logic                     funct7_b5,
  input  logic                     alu_src,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_stall
`endif
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(3);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(5);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(6);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(7);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(8);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(9);
  localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(10);
  localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(11);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(12);
  localparam logic [OPCODE_LENGTH-1:0] OP_BAD = '1;

  // ---------------- decode ----------------
  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_illegal;
  logic                     dec_shift;
  logic [DATA_WIDTH-1:0]    srcb_raw;
  logic [DATA_WIDTH-1:0]    dec_srcb;

  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        case (funct3)
          3'b000:         dec_op = OP_EQ;
          3'b001:         dec_op = OP_NE;
          3'b100, 3'b110: dec_op = OP_LT;
          3'b101, 3'b111: dec_op = OP_GE;
          default: begin
            dec_op      = OP_BAD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        // R-type and I-type share a table; only R-type honours funct7[5] for SUB
        case (funct3)
          3'b000:         dec_op = (funct7_b5 && (alu_op == 2'b10)) ? OP_SUB : OP_ADD;
          3'b001:         dec_op = OP_SLL;
          3'b010, 3'b011: dec_op = OP_SLT;
          3'b100:         dec_op = OP_XOR;
          3'b101:         dec_op = funct7_b5 ? OP_SRA : OP_SRL;
          3'b110:         dec_op = OP_OR;
          default:        dec_op = OP_AND;
        endcase
      end
    endcase
  end

  assign dec_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
  assign srcb_raw  = alu_src ? imm : rs2_data;
  assign dec_srcb  = dec_shift ? {{(DATA_WIDTH-5){1'b0}}, srcb_raw[4:0]} : srcb_raw;

  // ---------------- skid buffer ----------------
  logic                     main_valid_reg, main_valid_next;
  logic [OPCODE_LENGTH-1:0] main_op_reg, main_op_next;
  logic [DATA_WIDTH-1:0]    main_a_reg, main_a_next;
  logic [DATA_WIDTH-1:0]    main_b_reg, main_b_next;
  logic                     main_ill_reg, main_ill_next;
  logic                     skid_valid_reg, skid_valid_next;
  logic [OPCODE_LENGTH-1:0] skid_op_reg, skid_op_next;
  logic [DATA_WIDTH-1:0]    skid_a_reg, skid_a_next;
  logic [DATA_WIDTH-1:0]    skid_b_reg, skid_b_next;
  logic                     skid_ill_reg, skid_ill_next;
  logic                     accept;
  logic                     consume;

  // in_ready depends only on stored state, never on out_ready
  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign consume  = main_valid_reg & out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_op_next    = main_op_reg;
    main_a_next     = main_a_reg;
    main_b_next     = main_b_reg;
    main_ill_next   = main_ill_reg;
    skid_valid_next = skid_valid_reg;
    skid_op_next    = skid_op_reg;
    skid_a_next     = skid_a_reg;
    skid_b_next     = skid_b_reg;
    skid_ill_next   = skid_ill_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (consume && skid_valid_reg) begin
      // skid full implies in_ready low, so no accept can coincide with this move
      main_op_next    = skid_op_reg;
      main_a_next     = skid_a_reg;
      main_b_next     = skid_b_reg;
      main_ill_next   = skid_ill_reg;
      skid_valid_next = 1'b0;
    end else if (accept && (!main_valid_reg || consume)) begin
      main_valid_next = 1'b1;
      main_op_next    = dec_op;
      main_a_next     = rs1_data;
      main_b_next     = dec_srcb;
      main_ill_next   = dec_illegal;
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_op_next    = dec_op;
      skid_a_next     = rs1_data;
      skid_b_next     = dec_srcb;
      skid_ill_next   = dec_illegal;
    end else if (consume) begin
      main_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_reg <= 1'b0;
      main_op_reg    <= '0;
      main_a_reg     <= '0;
      main_b_reg     <= '0;
      main_ill_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_op_reg    <= '0;
      skid_a_reg     <= '0;
      skid_b_reg     <= '0;
      skid_ill_reg   <= 1'b0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_op_reg    <= main_op_next;
      main_a_reg     <= main_a_next;
      main_b_reg     <= main_b_next;
      main_ill_reg   <= main_ill_next;
      skid_valid_reg <= skid_valid_next;
      skid_op_reg    <= skid_op_next;
      skid_a_reg     <= skid_a_next;
      skid_b_reg     <= skid_b_next;
      skid_ill_reg   <= skid_ill_next;
    end
  end

  assign out_valid = main_valid_reg;
  assign Operation = main_op_reg;
  assign SrcA      = main_a_reg;
  assign SrcB      = main_b_reg;
  assign illegal   = main_ill_reg;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issued_reg;
  logic [31:0] stall_reg;

  // counters survive flush; only reset clears them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_reg <= '0;
      stall_reg  <= '0;
    end else begin
      if (main_valid_reg && out_ready)  issued_reg <= issued_reg + 32'd1;
      if (main_valid_reg && !out_ready) stall_reg  <= stall_reg + 32'd1;
    end
  end

  assign perf_issued = issued_reg;
  assign perf_stall  = stall_reg;
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- EX-stage issue register for the RV32I pipeline.
- Accepts decoded instruction fields from ID over a valid/ready handshake.
- Translates ALUOp/funct3/funct7[5] into the 4-bit ALU Operation code and selects the operand sources.
- Presents a registered, flushable operation bundle to the combinational ALU through a 2-entry skid buffer, so ID never sees a combinational ready path.

Parameters:
- DATA_WIDTH, 32, operand/immediate width
- OPCODE_LENGTH, 4, width of the Operation output

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries (branch mispredict)
- in_valid  in  1  ID bundle valid
- in_ready  out  1  issue stage can accept the ID bundle this cycle
- alu_op  in  2  00 mem/add, 01 branch, 10 R-type, 11 I-type ALU
- funct3  in  3  instruction funct3
- funct7_b5  in  1  instruction bit 30
- alu_src  in  1  1 = SrcB from imm, 0 = SrcB from rs2_data
- rs1_data  in  DATA_WIDTH  operand A
- rs2_data  in  DATA_WIDTH  register operand B
- imm  in  DATA_WIDTH  sign-extended immediate
- out_valid  out  1  EX bundle valid
- out_ready  in  1  EX consumes the bundle this cycle
- Operation  out  OPCODE_LENGTH  ALU operation code
- SrcA  out  DATA_WIDTH  ALU operand A
- SrcB  out  DATA_WIDTH  ALU operand B
- illegal  out  1  held bundle had an undecodable funct3

Behaviour:
- Decode is combinational on the ID inputs and is captured into the skid buffer.
- Op codes: AND 0, OR 1, ADD 2, SLL 3, SRL 4, SUB 5, SRA 6, SLT 7, EQ 8, NE 9, LT 10, GE 11, XOR 12.
- alu_op 00: ADD regardless of funct fields.
- alu_op 01, by funct3:
  - 000 -> 8, 001 -> 9, 100/110 -> 10, 101/111 -> 11.
  - 010/011 -> illegal = 1, Operation = 4'hF.
- alu_op 10, by funct3:
  - 000 -> funct7_b5 ? SUB : ADD
  - 001 -> SLL
  - 010/011 -> SLT
  - 100 -> XOR
  - 101 -> funct7_b5 ? SRA : SRL
  - 110 -> OR
  - 111 -> AND
- alu_op 11: same as 10, except funct3 000 -> ADD (funct7_b5 ignored).
- Operands:
  - SrcA = rs1_data.
  - SrcB = alu_src ? imm : rs2_data.
  - For SLL/SRL/SRA, SrcB is masked to its low 5 bits with upper bits zero.
- Storage: a main entry drives the outputs; a skid entry holds one extra bundle.
- in_ready = ~skid_valid, registered, with no combinational path from out_ready.
- Accept when in_valid & in_ready:
  - If main is empty, or main is being consumed (out_ready) while skid is empty, load main.
  - Otherwise load skid.
- Consume when out_valid & out_ready: skid moves to main if skid is valid; else main empties unless refilled the same cycle.
- Latency: accept at edge N -> out_valid at N+1.
- Throughput: 1 bundle/cycle when out_ready is held high.
- Order is strictly FIFO; no bundle is dropped or duplicated while out_ready is low.
- flush:
  - Clears main_valid and skid_valid at the next edge.
  - An in_valid bundle in the same cycle is discarded.
  - flush dominates accept and consume.
- Reset (async): out_valid = 0, in_ready = 1 after release, Operation = 0, SrcA = 0, SrcB = 0, illegal = 0, skid empty.
  - A bundle mid-handshake at reset is lost.
- Output stability: Operation/SrcA/SrcB/illegal stay stable while out_valid & ~out_ready.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined:
  - Adds outputs perf_issued (32) and perf_stall (32), both reset to 0 and wrapping at 2^32.
  - perf_issued increments on each out_valid & out_ready.
  - perf_stall increments on each out_valid & ~out_ready cycle.
  - flush does not clear the counters.
- Undefined: no counter ports or logic; all other behaviour is identical.

Test Plan:
- Reset asserted mid-stream with 2 entries held -> out_valid = 0, in_ready = 1, outputs 0 immediately, before the next edge.
- R-type funct3 = 000, funct7_b5 = 1, rs1 = 7, rs2 = 3, out_ready = 1 -> next cycle Operation = 5, SrcA = 7, SrcB = 3, illegal = 0.
- I-type funct3 = 101, funct7_b5 = 1, imm = 32'h0000_0423 -> Operation = 6, SrcB = 32'h3; same with funct3 = 000, funct7_b5 = 1 -> Operation = 2.
- Branch funct3 = 010 -> illegal = 1, Operation = 4'hF; funct3 = 111 -> Operation = 11, illegal = 0.
- Back-to-back bundles A, B, C with out_ready low for 3 cycles:
  - in_ready drops after B is held.
  - C waits.
  - On release, A, B, C emerge in order on consecutive cycles.
- flush with main and skid full plus in_valid = 1 -> next cycle out_valid = 0, in_ready = 1; the input bundle never appears.
